// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the memory bus controller: default widths and FSM state encoding.
package mem_bus_ctrl_pkg;

  localparam int unsigned DefAwidth = 5;
  localparam int unsigned DefDwidth = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Request/response handshake and memory control signals of the memory bus controller.
interface mem_bus_ctrl_if #(
  parameter int unsigned AWIDTH = mem_bus_ctrl_pkg::DefAwidth,
  parameter int unsigned DWIDTH = mem_bus_ctrl_pkg::DefDwidth
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DWIDTH-1:0] rsp_rdata;
  logic [AWIDTH-1:0] mem_addr;
  logic              mem_wr;
  logic              mem_rd;

  // Requester and memory side.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wr, mem_rd
  );

  // Controller side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_wr, mem_rd
  );

endinterface

// File: rtl/mem_bus_ctrl_bus_driver.sv
// Tristate driver for the shared memory data bus.
module bus_driver #(
  parameter int unsigned DWIDTH = mem_bus_ctrl_pkg::DefDwidth
) (
  input  logic              en_i,
  input  logic [DWIDTH-1:0] data_i,
  inout  wire  [DWIDTH-1:0] bus_io
);

  assign bus_io = en_i ? data_i : {DWIDTH{1'bz}};

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-outstanding memory bus controller: IDLE -> ACCESS (one cycle) -> RESP handshake.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned AWIDTH = DefAwidth,
  parameter int unsigned DWIDTH = DefDwidth
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_ctrl_if.slave     bus,
  inout  wire  [DWIDTH-1:0] mem_data
);

  state_e            state_q, state_d;
  logic              we_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [DWIDTH-1:0] rdata_q;
  logic              drive_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && bus.req_valid) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      // Write responses carry zero data; reads capture the bus as ACCESS ends.
      if (state_q == StAccess) begin
        rdata_q <= we_q ? '0 : mem_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.req_valid) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   if (bus.rsp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wr    = (state_q == StAccess) && we_q;
  assign bus.mem_rd    = (state_q == StAccess) && !we_q;

  // Bus is only driven during a write ACCESS, so a read is always followed by a released cycle.
  assign drive_en = (state_q == StAccess) && we_q;

  bus_driver #(
    .DWIDTH(DWIDTH)
  ) u_bus_driver (
    .en_i  (drive_en),
    .data_i(wdata_q),
    .bus_io(mem_data)
  );

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: vector table, corner sequences and random traffic.
module tb_mem_bus_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  wire [DW-1:0] mem_data;

  mem_bus_ctrl_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  mem_bus_ctrl #(
    .AWIDTH(AW),
    .DWIDTH(DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Bus-level memory: drives data while read strobe is high, captures on write strobe.
  logic [DW-1:0] mem_arr [2**AW];
  assign mem_data = bus.mem_rd ? mem_arr[bus.mem_addr] : {DW{1'bz}};
  always @(posedge clk) if (bus.mem_wr) mem_arr[bus.mem_addr] <= mem_data;

  // Transaction-level reference: what each address should hold.
  logic [DW-1:0] ref_mem [2**AW];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobe exclusivity and read->write turnaround, every cycle.
  logic prev_rd = 1'b0;
  always @(negedge clk) begin
    n_cmp += 2;
    if (bus.mem_wr && bus.mem_rd) begin
      n_bad++;
      $display("FAIL wr_rd_overlap: got both strobes high expected at most one at %0t", $time);
    end
    if (prev_rd && bus.mem_wr) begin
      n_bad++;
      $display("FAIL turnaround: got write right after read expected a released cycle at %0t",
               $time);
    end
    prev_rd = bus.mem_rd;
  end

  task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                     input int hold, output logic [DW-1:0] rd);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    while (!bus.req_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("access_ctrl", {bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.rsp_valid, bus.req_ready},
        {we, ~we, addr, 1'b0, 1'b0});
    if (we) chk("access_wdata", 32'(mem_data), 32'(wd));
    @(posedge clk); #1;
    chk("resp_enter", {bus.rsp_valid, bus.req_ready, bus.mem_wr, bus.mem_rd}, 4'b1000);
    rd = bus.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("resp_hold", {bus.rsp_valid, bus.req_ready, bus.rsp_rdata}, {1'b1, 1'b0, rd});
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("resp_done", {bus.rsp_valid, bus.req_ready}, 2'b01);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] rd;
    logic          rwe;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdat;

    tbl[0] = '{we: 1'b1, addr: 5'd0,  wdata: 8'hff, exp: 8'h00};
    tbl[1] = '{we: 1'b0, addr: 5'd0,  wdata: 8'h00, exp: 8'hff};
    tbl[2] = '{we: 1'b1, addr: 5'd31, wdata: 8'h00, exp: 8'h00};
    tbl[3] = '{we: 1'b0, addr: 5'd31, wdata: 8'h00, exp: 8'h00};
    tbl[4] = '{we: 1'b0, addr: 5'd0,  wdata: 8'h00, exp: 8'hff};

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset state.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {bus.req_ready, bus.rsp_valid, bus.mem_wr, bus.mem_rd, bus.mem_addr,
        bus.rsp_rdata}, {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0});
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_release", {bus.req_ready, bus.rsp_valid}, 2'b10);

    foreach (tbl[i]) begin
      txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, 0, rd);
      chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(tbl[i].exp));
      if (tbl[i].we) ref_mem[tbl[i].addr] = tbl[i].wdata;
    end

    // Descending addresses 31..1 get ascending data 0..30.
    for (int i = 0; i < 31; i++) begin
      txn(1'b1, AW'(31 - i), DW'(i), 0, rd);
      ref_mem[31 - i] = DW'(i);
    end
    for (int i = 0; i < 31; i++) begin
      txn(1'b0, AW'(31 - i), 8'h00, 0, rd);
      chk("sweep_read", 32'(rd), 32'(i));
    end

    // Response stalled for 4 cycles.
    txn(1'b0, 5'd0, 8'h00, 4, rd);
    chk("stall_rdata", 32'(rd), 32'(ref_mem[0]));

    // Read followed by a write held on req_valid through ACCESS/RESP.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 5'd5;
    @(posedge clk); #1;
    chk("b2b_read_access", {bus.mem_rd, bus.mem_wr, bus.mem_addr}, {1'b1, 1'b0, 5'd5});
    bus.req_we    = 1'b1;
    bus.req_addr  = 5'd6;
    bus.req_wdata = 8'hc3;
    @(posedge clk); #1;
    chk("b2b_read_resp", {bus.rsp_valid, bus.req_ready, bus.rsp_rdata},
        {1'b1, 1'b0, ref_mem[5]});
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("b2b_idle", {bus.req_ready, bus.mem_wr, bus.mem_rd}, 3'b100);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("b2b_write_access", {bus.mem_wr, bus.mem_rd, bus.mem_addr, mem_data},
        {1'b1, 1'b0, 5'd6, 8'hc3});
    @(posedge clk); #1;
    chk("b2b_write_resp", {bus.rsp_valid, bus.rsp_rdata}, {1'b1, 8'h00});
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    ref_mem[6] = 8'hc3;

    // Reset during a write ACCESS.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 5'd3;
    bus.req_wdata = 8'haa;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rst_access_pre", 32'(bus.mem_wr), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_access_state", {bus.mem_wr, bus.mem_rd, bus.rsp_valid, bus.req_ready,
        bus.mem_addr}, {1'b0, 1'b0, 1'b0, 1'b1, 5'd0});
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_access_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    txn(1'b1, 5'd3, 8'h3c, 0, rd);
    ref_mem[3] = 8'h3c;

    // Reset during RESP of a read with nonzero data.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 5'd0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_resp_pre", {bus.rsp_valid, bus.rsp_rdata}, {1'b1, ref_mem[0]});
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_resp_state", {bus.rsp_valid, bus.req_ready, bus.rsp_rdata}, {1'b0, 1'b1, 8'h00});
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_resp_dropped", 32'(bus.rsp_valid), 32'd0);

    // Random traffic against the reference memory.
    for (int i = 0; i < 200; i++) begin
      rwe   = 1'($urandom_range(0, 1));
      raddr = AW'($urandom);
      rdat  = DW'($urandom);
      txn(rwe, raddr, rdat, int'($urandom_range(0, 3)), rd);
      if (rwe) begin
        chk("rand_write_rsp", 32'(rd), 32'd0);
        ref_mem[raddr] = rdat;
      end else begin
        chk("rand_read_rsp", 32'(rd), 32'(ref_mem[raddr]));
      end
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
